// File: rtl/spart_mmio_bridge_pkg.sv
// Shared register offsets, status bit indices and FSM encodings for the SPART MMIO bridge.
package spart_mmio_bridge_pkg;

    localparam logic [31:0] DataOffset   = 32'h0000_0000;
    localparam logic [31:0] StatusOffset = 32'h0000_0004;

    localparam int unsigned StTxReady = 0;
    localparam int unsigned StRxValid = 1;
    localparam int unsigned ErrClrBit = 4;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_ISSUE,
        TX_WAIT_RDY,
        TX_WAIT_BUSY,
        TX_WAIT_DONE
    } tx_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_REQ,
        R_ACK
    } rx_state_e;

    function automatic logic [31:0] status_word(input logic err, input logic full,
                                                input logic empty, input logic [1:0] drv);
        return {27'b0, err, full, empty, drv};
    endfunction

endpackage

// File: rtl/spart_mmio_bridge_if.sv
// CPU/cache-side word bus into the SPART MMIO bridge; master = CPU, slave = bridge.
interface spart_mmio_bridge_if;

    logic [31:0] cpu_addr;
    logic        cpu_we;
    logic        cpu_re;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_rvalid;
    logic        cpu_stall;

    modport master (
        output cpu_addr, cpu_we, cpu_re, cpu_wdata,
        input  cpu_rdata, cpu_rvalid, cpu_stall
    );

    modport slave (
        input  cpu_addr, cpu_we, cpu_re, cpu_wdata,
        output cpu_rdata, cpu_rvalid, cpu_stall
    );

endinterface

// File: rtl/spart_mmio_bridge_tx_fifo.sv
// Synchronous TX FIFO with wrap-bit pointers; head is the oldest word, valid when not empty.
module spart_mmio_bridge_tx_fifo #(
    parameter int unsigned DepthLog2 = 2,
    parameter int unsigned Width     = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int unsigned Depth = 2 ** DepthLog2;
    localparam logic [DepthLog2:0] PtrOne = {{DepthLog2{1'b0}}, 1'b1};

    logic [DepthLog2:0] wr_ptr;
    logic [DepthLog2:0] rd_ptr;
    logic [Width-1:0]   mem [Depth];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DepthLog2] != rd_ptr[DepthLog2]) &&
                   (wr_ptr[DepthLog2-1:0] == rd_ptr[DepthLog2-1:0]);
    assign head  = mem[rd_ptr[DepthLog2-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + PtrOne;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + PtrOne;
            end
        end
    end

    // Storage needs no reset: a word is only observable after it was pushed.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[DepthLog2-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/spart_mmio_bridge.sv
// MMIO front end for the SPART driver: DATA/STATUS decode, TX FIFO drain and RX read requests.
// Optional watchdog on the TX handshake: define SPART_TX_TIMEOUT_EN.
module spart_mmio_bridge
    import spart_mmio_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'hFFFF_0000,
    parameter int unsigned TX_DEPTH_LOG2  = 2,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic                clk,
    input  logic                rst,
    spart_mmio_bridge_if.slave  bus,
    output logic                spart_data_wren,
    output logic                spart_data_rden,
    output logic                clear_status_rd,
    output logic [31:0]         data_tx,
    input  logic [31:0]         data_rx,
    input  logic [31:0]         status_register,
    input  logic                data_rdy
);

    tx_state_e   tx_state;
    rx_state_e   rx_state;
    logic        rx_done;
    logic        err;
    logic        tmo_hit;

    logic        hit_data, hit_status;
    logic        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [31:0] fifo_head;
    logic        tx_ready, rx_valid;
    logic        tx_blocks_rd, rx_idle, rx_start, rd_simple, err_clr, tx_go;
    logic        unused_status;

    assign unused_status = ^status_register[31:2];
    assign tx_ready      = status_register[StTxReady];
    assign rx_valid      = status_register[StRxValid];

    assign hit_data   = (bus.cpu_addr == BASE_ADDR + DataOffset);
    assign hit_status = (bus.cpu_addr == BASE_ADDR + StatusOffset);

    assign tx_blocks_rd = (tx_state == TX_ISSUE) || (tx_state == TX_WAIT_RDY);
    assign rx_idle      = (rx_state == R_IDLE);

    // rx_done marks the cycle where the held DATA read completes; it must not restart.
    assign bus.cpu_stall = (bus.cpu_re && hit_data && !rx_done &&
                            (tx_blocks_rd || !rx_idle || rx_valid)) ||
                           (bus.cpu_we && hit_data && fifo_full);

    assign rx_start  = bus.cpu_re && hit_data && !rx_done && !tx_blocks_rd && rx_idle && rx_valid;
    assign rd_simple = bus.cpu_re && !bus.cpu_stall && !rx_done;
    assign fifo_push = bus.cpu_we && hit_data && !fifo_full;
    assign err_clr   = bus.cpu_we && hit_status && bus.cpu_wdata[ErrClrBit];
    assign fifo_pop  = ((tx_state == TX_WAIT_DONE) && tx_ready) || tmo_hit;
    // A read starting this cycle wins so wren and rden never coincide.
    assign tx_go     = !fifo_empty && tx_ready && rx_idle && !rx_start;

    spart_mmio_bridge_tx_fifo #(
        .DepthLog2 (TX_DEPTH_LOG2),
        .Width     (32)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (bus.cpu_wdata),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

`ifdef SPART_TX_TIMEOUT_EN
    logic [15:0] tmo_cnt;
    logic        tx_waiting, tx_advance;

    assign tx_waiting = (tx_state == TX_WAIT_RDY) || (tx_state == TX_WAIT_BUSY) ||
                        (tx_state == TX_WAIT_DONE);
    assign tmo_hit    = tx_waiting && (tmo_cnt == TIMEOUT_CYCLES);
    assign tx_advance = tmo_hit ||
                        ((tx_state == TX_WAIT_RDY) && data_rdy) ||
                        ((tx_state == TX_WAIT_BUSY) && !tx_ready) ||
                        ((tx_state == TX_WAIT_DONE) && tx_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            err     <= 1'b0;
        end else begin
            tmo_cnt <= (tx_waiting && !tx_advance) ? tmo_cnt + 16'd1 : 16'd0;
            if (tmo_hit) begin
                err <= 1'b1;
            end else if (err_clr) begin
                err <= 1'b0;
            end
        end
    end
`else
    logic [16:0] unused_cfg;

    assign unused_cfg = {TIMEOUT_CYCLES, err_clr};
    assign tmo_hit    = 1'b0;
    assign err        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state        <= TX_IDLE;
            spart_data_wren <= 1'b0;
            data_tx         <= '0;
        end else begin
            spart_data_wren <= 1'b0;
            case (tx_state)
                TX_IDLE: begin
                    if (tx_go) begin
                        tx_state        <= TX_ISSUE;
                        spart_data_wren <= 1'b1;
                        data_tx         <= fifo_head;
                    end
                end
                TX_ISSUE:     tx_state <= TX_WAIT_RDY;
                TX_WAIT_RDY: begin
                    if (tmo_hit)       tx_state <= TX_IDLE;
                    else if (data_rdy) tx_state <= TX_WAIT_BUSY;
                end
                TX_WAIT_BUSY: begin
                    if (tmo_hit)        tx_state <= TX_IDLE;
                    else if (!tx_ready) tx_state <= TX_WAIT_DONE;
                end
                TX_WAIT_DONE: begin
                    if (tmo_hit || tx_ready) tx_state <= TX_IDLE;
                end
                default:      tx_state <= TX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state        <= R_IDLE;
            spart_data_rden <= 1'b0;
            clear_status_rd <= 1'b0;
            bus.cpu_rdata   <= '0;
            bus.cpu_rvalid  <= 1'b0;
            rx_done         <= 1'b0;
        end else begin
            spart_data_rden <= 1'b0;
            clear_status_rd <= 1'b0;
            bus.cpu_rvalid  <= 1'b0;
            rx_done         <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    if (rx_start) begin
                        rx_state        <= R_REQ;
                        spart_data_rden <= 1'b1;
                        clear_status_rd <= 1'b1;
                    end else if (rd_simple) begin
                        bus.cpu_rvalid <= 1'b1;
                        bus.cpu_rdata  <= hit_status ?
                            status_word(err, fifo_full, fifo_empty, status_register[1:0]) : '0;
                    end
                end
                R_REQ: begin
                    bus.cpu_rdata <= data_rx;
                    rx_state      <= R_ACK;
                end
                R_ACK: begin
                    if (data_rdy) begin
                        bus.cpu_rvalid <= 1'b1;
                        rx_done        <= 1'b1;
                        rx_state       <= R_IDLE;
                    end
                end
                default: rx_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spart_mmio_bridge.sv
// Self-checking bench for spart_mmio_bridge: reactive SPART driver model plus TX/RX scoreboards.
module tb_spart_mmio_bridge;

    localparam logic [31:0] Base = 32'hFFFF_0000;
    localparam logic [31:0] Stat = 32'hFFFF_0004;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wren, rden, clr;
    logic [31:0] data_tx;
    logic [31:0] data_rx = 32'h0;
    logic [31:0] status_register;
    logic        data_rdy = 1'b0;

    always #5 clk = ~clk;

    spart_mmio_bridge_if bus();

    spart_mmio_bridge #(
        .BASE_ADDR      (Base),
        .TX_DEPTH_LOG2  (2),
        .TIMEOUT_CYCLES (16'd40)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .spart_data_wren (wren),
        .spart_data_rden (rden),
        .clear_status_rd (clr),
        .data_tx         (data_tx),
        .data_rx         (data_rx),
        .status_register (status_register),
        .data_rdy        (data_rdy)
    );

    // Driver model state
    int busy = 0;
    bit stuck = 1'b0;
    bit stick_mode = 1'b0;
    bit hold_off = 1'b0;
    bit rdy_pend = 1'b0;
    bit tx_ready = 1'b1;
    int rx_posted = 0;
    int rx_taken = 0;

    assign status_register = {30'b0, (rx_posted != rx_taken), tx_ready};

    // Scoreboards and counters
    logic [31:0] exp_tx[$];
    logic [31:0] exp_rd[$];
    int n_checks = 0;
    int n_pass = 0;
    int cyc = 0;
    int wren_cnt = 0;
    int rden_cnt = 0;
    int last_wren = 0;
    int last_rden = 0;

    always @(posedge clk) begin
        #1;
        data_rdy = rdy_pend;
        rdy_pend = wren | rden;
        if (clr) rx_taken++;
        if (busy > 0) busy--;
        if (!stick_mode) stuck = 1'b0;
        if (wren) begin
            if (stick_mode) stuck = 1'b1;
            else busy = 3;
        end
        tx_ready = (busy == 0) && !stuck && !hold_off;
    end

    always @(posedge clk) begin
        logic [31:0] e;
        #1;
        cyc++;
        if (wren) begin
            wren_cnt++;
            last_wren = cyc;
            n_checks++;
            if (exp_tx.size() == 0) begin
                $display("FAIL tx_unexpected data_tx=%h expected=none", data_tx);
            end else begin
                e = exp_tx.pop_front();
                if (data_tx !== e) $display("FAIL tx_order data_tx=%h expected=%h", data_tx, e);
                else n_pass++;
            end
        end
        if (rden) begin
            rden_cnt++;
            last_rden = cyc;
        end
        if (wren || rden) begin
            n_checks++;
            if ((wren && rden) || (rden !== clr))
                $display("FAIL strobe_excl wren=%b rden=%b clr=%b expected=no overlap, rden==clr",
                         wren, rden, clr);
            else n_pass++;
        end
        if (bus.cpu_rvalid) begin
            n_checks++;
            if (exp_rd.size() == 0) begin
                $display("FAIL rd_unexpected rdata=%h expected=none", bus.cpu_rdata);
            end else begin
                e = exp_rd.pop_front();
                if (bus.cpu_rdata !== e)
                    $display("FAIL rd_data rdata=%h expected=%h", bus.cpu_rdata, e);
                else n_pass++;
            end
        end
    end

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data, output int stalls);
        @(negedge clk);
        bus.cpu_addr = addr;
        bus.cpu_wdata = data;
        bus.cpu_we = 1'b1;
        #1;
        stalls = 0;
        while (bus.cpu_stall && stalls < 2000) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 2000) begin
            n_checks++;
            $display("FAIL write_timeout addr=%h stalled=%0d limit=2000", addr, stalls);
        end else if (addr == Base) begin
            exp_tx.push_back(data);
        end
        @(negedge clk);
        bus.cpu_we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, output int stalls);
        @(negedge clk);
        bus.cpu_addr = addr;
        bus.cpu_re = 1'b1;
        exp_rd.push_back(exp);
        #1;
        stalls = 0;
        while (bus.cpu_stall && stalls < 2000) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (stalls >= 2000) begin
            n_checks++;
            $display("FAIL read_timeout addr=%h stalled=%0d limit=2000", addr, stalls);
        end
        @(negedge clk);
        bus.cpu_re = 1'b0;
    endtask

    task automatic wait_wrens(input int target);
        int n = 0;
        while (wren_cnt < target && n < 500) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        int st;
        bus.cpu_addr = '0;
        bus.cpu_wdata = '0;
        bus.cpu_we = 1'b0;
        bus.cpu_re = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({wren, rden, clr} !== 3'b000) $display("FAIL rst_strobes got=%b expected=000", {wren, rden, clr});
        else n_pass++;
        n_checks++;
        if (data_tx !== 32'h0) $display("FAIL rst_data_tx got=%h expected=0", data_tx);
        else n_pass++;
        n_checks++;
        if ({bus.cpu_rvalid, bus.cpu_rdata} !== 33'h0)
            $display("FAIL rst_rd got=%b/%h expected=0/0", bus.cpu_rvalid, bus.cpu_rdata);
        else n_pass++;
        n_checks++;
        if (bus.cpu_stall !== 1'b0) $display("FAIL rst_stall got=%b expected=0", bus.cpu_stall);
        else n_pass++;
        bus_read(Stat, 32'h5, st);
    endtask

    task automatic test_single_write();
        int st;
        int base = wren_cnt;
        bus_write(Base, 32'hDEAD_BEEF, st);
        wait_wrens(base + 1);
        repeat (10) @(negedge clk);
        n_checks++;
        if (wren_cnt - base !== 1) $display("FAIL single_wren_count got=%0d expected=1", wren_cnt - base);
        else n_pass++;
        n_checks++;
        if (data_tx !== 32'hDEAD_BEEF) $display("FAIL single_data_hold got=%h expected=deadbeef", data_tx);
        else n_pass++;
        bus_read(Stat, 32'h5, st);
    endtask

    task automatic test_fifo_full();
        int st;
        int st5 = 0;
        int base = wren_cnt;
        stick_mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_write(Base, 32'hA000_0000 + i, st);
            n_checks++;
            if (st !== 0) $display("FAIL fill_stall word=%0d got=%0d expected=0", i, st);
            else n_pass++;
        end
        fork
            bus_write(Base, 32'hA000_0004, st5);
            begin
                repeat (15) @(negedge clk);
                stick_mode = 1'b0;
            end
        join
        n_checks++;
        if (st5 < 10) $display("FAIL full_stall got=%0d expected>=10", st5);
        else n_pass++;
        wait_wrens(base + 5);
        repeat (12) @(negedge clk);
        n_checks++;
        if (wren_cnt - base !== 5) $display("FAIL full_wren_count got=%0d expected=5", wren_cnt - base);
        else n_pass++;
        bus_read(Stat, 32'h5, st);
    endtask

    task automatic test_rx_read();
        int st;
        int base = rden_cnt;
        data_rx = 32'h1234_5678;
        rx_posted++;
        bus_read(Base, 32'h1234_5678, st);
        n_checks++;
        if (rden_cnt - base !== 1) $display("FAIL rx_rden_count got=%0d expected=1", rden_cnt - base);
        else n_pass++;
        n_checks++;
        if (st < 2) $display("FAIL rx_stall got=%0d expected>=2", st);
        else n_pass++;
        bus_read(Stat, 32'h5, st);
    endtask

    task automatic test_rx_empty();
        int st;
        int base = rden_cnt;
        bus_read(Base, 32'h0, st);
        n_checks++;
        if (st !== 0) $display("FAIL rx_empty_stall got=%0d expected=0", st);
        else n_pass++;
        n_checks++;
        if (rden_cnt !== base) $display("FAIL rx_empty_rden got=%0d expected=0", rden_cnt - base);
        else n_pass++;
    endtask

    task automatic test_read_during_issue();
        int st;
        int base = wren_cnt;
        data_rx = 32'hCAFE_F00D;
        rx_posted++;
        bus_write(Base, 32'h0BAD_F00D, st);
        bus_read(Base, 32'hCAFE_F00D, st);
        n_checks++;
        if (st < 4) $display("FAIL issue_rd_stall got=%0d expected>=4", st);
        else n_pass++;
        n_checks++;
        if (last_rden - last_wren < 3)
            $display("FAIL issue_rd_order rden-wren=%0d expected>=3", last_rden - last_wren);
        else n_pass++;
        repeat (10) @(negedge clk);
        n_checks++;
        if (wren_cnt - base !== 1) $display("FAIL issue_wren_count got=%0d expected=1", wren_cnt - base);
        else n_pass++;
    endtask

    task automatic test_decode();
        int st;
        int base = wren_cnt;
        bus_read(Base + 32'h8, 32'h0, st);
        bus_write(Base + 32'h8, 32'h1111_1111, st);
        bus_write(Stat, 32'hFFFF_FFFF, st);
        repeat (10) @(negedge clk);
        n_checks++;
        if (wren_cnt !== base) $display("FAIL decode_wren got=%0d expected=0", wren_cnt - base);
        else n_pass++;
        bus_read(Stat, 32'h5, st);
    endtask

    task automatic test_reset_mid();
        int st;
        int base = wren_cnt;
        hold_off = 1'b1;
        stick_mode = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) bus_write(Base, 32'hB000_0000 + i, st);
        hold_off = 1'b0;
        wait_wrens(base + 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_tx.delete();
        #1;
        n_checks++;
        if ({wren, data_tx} !== 33'h0) $display("FAIL midrst_out got=%b/%h expected=0/0", wren, data_tx);
        else n_pass++;
        bus_read(Stat, 32'h4, st);
        base = wren_cnt;
        stick_mode = 1'b0;
        repeat (20) @(negedge clk);
        n_checks++;
        if (wren_cnt !== base) $display("FAIL midrst_dropped got=%0d expected=0", wren_cnt - base);
        else n_pass++;
        bus_read(Stat, 32'h5, st);
    endtask

`ifdef SPART_TX_TIMEOUT_EN
    task automatic test_timeout();
        int st;
        int base = wren_cnt;
        stick_mode = 1'b1;
        bus_write(Base, 32'hC0DE_0001, st);
        wait_wrens(base + 1);
        repeat (60) @(negedge clk);
        bus_read(Stat, 32'h14, st);
        stick_mode = 1'b0;
        repeat (5) @(negedge clk);
        bus_read(Stat, 32'h15, st);
        bus_write(Stat, 32'h10, st);
        bus_read(Stat, 32'h5, st);
    endtask
`endif

    task automatic test_drain();
        repeat (5) @(negedge clk);
        n_checks++;
        if (exp_tx.size() !== 0) $display("FAIL drain_tx left=%0d expected=0", exp_tx.size());
        else n_pass++;
        n_checks++;
        if (exp_rd.size() !== 0) $display("FAIL drain_rd left=%0d expected=0", exp_rd.size());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fifo_full();
        test_rx_read();
        test_rx_empty();
        test_read_during_issue();
        test_decode();
        test_reset_mid();
`ifdef SPART_TX_TIMEOUT_EN
        test_timeout();
`endif
        test_drain();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout sim_time=%0t limit=200000", $time);
        $fatal(1);
    end

endmodule
